// File: rtl/scr1_dmem_router_pkg.sv
// Router-local types: port select index and the decode-error select value.
package scr1_dmem_router_pkg;

    localparam int unsigned SCR1_DMEM_ROUTER_PORT_MAX = 8;
    localparam int unsigned SCR1_DMEM_ROUTER_SEL_W    = 4;

    typedef logic [SCR1_DMEM_ROUTER_SEL_W-1:0] type_scr1_dmem_sel_t;

    // Decode-error select is the index one past the last real port
    function automatic type_scr1_dmem_sel_t scr1_dmem_sel_err(input int unsigned port_num);
        return SCR1_DMEM_ROUTER_SEL_W'(port_num);
    endfunction

endpackage

// File: rtl/scr1_memif_pkg.sv
// Shared memory-interface types: command, access width and response codes.
package scr1_memif_pkg;

    localparam int unsigned SCR1_DMEM_AWIDTH = 32;
    localparam int unsigned SCR1_DMEM_DWIDTH = 32;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    // A 1-bit command has no spare code; idle ports simply see a read with req low
    localparam type_scr1_mem_cmd_e SCR1_MEM_CMD_ERROR = SCR1_MEM_CMD_RD;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10,
        SCR1_MEM_WIDTH_ERROR = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10,
        SCR1_MEM_RESP_RSVD   = 2'b11
    } type_scr1_mem_resp_e;

endpackage

// File: rtl/scr1_dmem_router_fifo.sv
// In-order tracker FIFO holding the target select of each in-flight transaction.
module scr1_dmem_router_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic             one_left,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [WIDTH-1:0] mem_q [2**PTR_W];
    logic [WIDTH-1:0] mem_d [2**PTR_W];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign one_left = (count_q == CNT_W'(1));
    assign head     = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset; occupancy is governed by count_q
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(pop && empty));
            assert (!(push && full && !pop));
        end
    end

endmodule

// File: rtl/scr1_dmem_router_mp.sv
// Data-memory router: address decode to PORT_NUM targets with in-order
// tracking of up to OUTSTD outstanding transactions to a single target.
module scr1_dmem_router_mp
    import scr1_memif_pkg::*;
    import scr1_dmem_router_pkg::*;
#(
    parameter int unsigned PORT_NUM = 4,
    parameter int unsigned OUTSTD   = 2,
    parameter logic [PORT_NUM-1:0][SCR1_DMEM_AWIDTH-1:0] ADDR_MASK =
        {32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000},
    parameter logic [PORT_NUM-1:0][SCR1_DMEM_AWIDTH-1:0] ADDR_PATTERN =
        {32'h0003_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000},
    parameter bit DFLT_EN = 1'b1
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       dmem_req,
    input  type_scr1_mem_cmd_e                         dmem_cmd,
    input  type_scr1_mem_width_e                       dmem_width,
    input  logic [SCR1_DMEM_AWIDTH-1:0]                dmem_addr,
    input  logic [SCR1_DMEM_DWIDTH-1:0]                dmem_wdata,
    output logic                                       dmem_req_ack,
    output logic [SCR1_DMEM_DWIDTH-1:0]                dmem_rdata,
    output type_scr1_mem_resp_e                        dmem_resp,
    output logic [PORT_NUM-1:0]                        port_req,
    output logic [PORT_NUM-1:0]                        port_cmd,
    output logic [PORT_NUM-1:0][1:0]                   port_width,
    output logic [PORT_NUM-1:0][SCR1_DMEM_AWIDTH-1:0]  port_addr,
    output logic [PORT_NUM-1:0][SCR1_DMEM_DWIDTH-1:0]  port_wdata,
    input  logic [PORT_NUM-1:0]                        port_req_ack,
    input  logic [PORT_NUM-1:0][SCR1_DMEM_DWIDTH-1:0]  port_rdata,
    input  logic [PORT_NUM-1:0][1:0]                   port_resp
);

    localparam int unsigned         SEL_W   = SCR1_DMEM_ROUTER_SEL_W;
    localparam type_scr1_dmem_sel_t SEL_ERR = scr1_dmem_sel_err(PORT_NUM);

    type_scr1_dmem_sel_t         sel;
    type_scr1_dmem_sel_t         head;
    logic                        trk_full;
    logic                        trk_empty;
    logic                        trk_one_left;
    logic                        trk_push;
    logic                        trk_pop;
    logic                        issue_ok;
    logic                        tgt_ack;
    type_scr1_mem_resp_e         head_resp;
    logic [SCR1_DMEM_DWIDTH-1:0] head_rdata;

    // Lowest matching index wins, so scan downward and let lower indices overwrite
    always_comb begin
        sel = DFLT_EN ? '0 : SEL_ERR;
        for (int i = int'(PORT_NUM) - 1; i >= 0; i--) begin
            if ((dmem_addr & ADDR_MASK[i]) == ADDR_PATTERN[i]) begin
                sel = SEL_W'(i);
            end
        end
    end

    // Response from the oldest in-flight target; decode errors complete on their own
    always_comb begin
        head_resp  = SCR1_MEM_RESP_NOTRDY;
        head_rdata = '0;
        if (rst_n && !trk_empty) begin
            if (head == SEL_ERR) begin
                head_resp = SCR1_MEM_RESP_RDY_ER;
            end else begin
                for (int i = 0; i < int'(PORT_NUM); i++) begin
                    if (head == SEL_W'(i)) begin
                        head_resp  = type_scr1_mem_resp_e'(port_resp[i]);
                        head_rdata = port_rdata[i];
                    end
                end
            end
        end
    end

    assign trk_pop = (head_resp == SCR1_MEM_RESP_RDY_OK) || (head_resp == SCR1_MEM_RESP_RDY_ER);

    // Only one target may own the in-flight window so responses stay ordered
    assign issue_ok = rst_n && (!trk_full || trk_pop)
                    && (trk_empty || (sel == head) || (trk_pop && trk_one_left));

    always_comb begin
        tgt_ack = (sel == SEL_ERR);
        for (int i = 0; i < int'(PORT_NUM); i++) begin
            if (sel == SEL_W'(i)) begin
                tgt_ack = port_req_ack[i];
            end
        end
    end

    assign dmem_req_ack = issue_ok && tgt_ack;
    assign trk_push     = dmem_req && dmem_req_ack;
    assign dmem_resp    = head_resp;
    assign dmem_rdata   = head_rdata;

    always_comb begin
        for (int i = 0; i < int'(PORT_NUM); i++) begin
            port_req[i]   = 1'b0;
            port_cmd[i]   = SCR1_MEM_CMD_ERROR;
            port_width[i] = SCR1_MEM_WIDTH_ERROR;
            port_addr[i]  = '0;
            port_wdata[i] = '0;
            if (sel == SEL_W'(i)) begin
                port_req[i]   = dmem_req && issue_ok;
                port_cmd[i]   = dmem_cmd;
                port_width[i] = dmem_width;
                port_addr[i]  = dmem_addr;
                port_wdata[i] = dmem_wdata;
            end
        end
    end

    scr1_dmem_router_fifo #(
        .DEPTH (OUTSTD),
        .WIDTH (SEL_W)
    ) u_tracker (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (trk_push),
        .pop      (trk_pop),
        .wdata    (sel),
        .full     (trk_full),
        .empty    (trk_empty),
        .one_left (trk_one_left),
        .head     (head)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (dmem_req) begin
                assert (!$isunknown({sel, dmem_cmd, dmem_width}));
            end
            assert ($onehot0(port_req));
        end
    end

endmodule

// File: tb/tb_scr1_dmem_router_mp.sv
// Directed bench for the dmem router: scoreboard of expected core responses
// checked by a negedge monitor, plus inline handshake checks.
module tb_scr1_dmem_router_mp;
    import scr1_memif_pkg::*;
    import scr1_dmem_router_pkg::*;

    localparam int unsigned PN = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                        rst_n;
    logic                        dmem_req;
    type_scr1_mem_cmd_e          dmem_cmd;
    type_scr1_mem_width_e        dmem_width;
    logic [31:0]                 dmem_addr;
    logic [31:0]                 dmem_wdata;
    logic                        dmem_req_ack;
    logic [31:0]                 dmem_rdata;
    type_scr1_mem_resp_e         dmem_resp;
    logic [PN-1:0]               port_req;
    logic [PN-1:0]               port_cmd;
    logic [PN-1:0][1:0]          port_width;
    logic [PN-1:0][31:0]         port_addr;
    logic [PN-1:0][31:0]         port_wdata;
    logic [PN-1:0]               port_req_ack;
    logic [PN-1:0][31:0]         port_rdata;
    logic [PN-1:0][1:0]          port_resp;

    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;

    scr1_dmem_router_mp #(
        .PORT_NUM     (PN),
        .OUTSTD       (2),
        .ADDR_MASK    ({32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000}),
        .ADDR_PATTERN ({32'h0003_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000}),
        .DFLT_EN      (1'b0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dmem_req     (dmem_req),
        .dmem_cmd     (dmem_cmd),
        .dmem_width   (dmem_width),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_req_ack (dmem_req_ack),
        .dmem_rdata   (dmem_rdata),
        .dmem_resp    (dmem_resp),
        .port_req     (port_req),
        .port_cmd     (port_cmd),
        .port_width   (port_width),
        .port_addr    (port_addr),
        .port_wdata   (port_wdata),
        .port_req_ack (port_req_ack),
        .port_rdata   (port_rdata),
        .port_resp    (port_resp)
    );

    // Every completed core response must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1 && dmem_resp != SCR1_MEM_RESP_NOTRDY) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got resp=%0d rdata=%h, required no response",
                         dmem_resp, dmem_rdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (dmem_resp !== mon_e.resp || dmem_rdata !== mon_e.rdata) begin
                    n_fail++;
                    $display("FAIL sb_resp: got resp=%0d rdata=%h, required resp=%0d rdata=%h",
                             dmem_resp, dmem_rdata, mon_e.resp, mon_e.rdata);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dmem_req     = 1'b0;
        dmem_cmd     = SCR1_MEM_CMD_RD;
        dmem_width   = SCR1_MEM_WIDTH_WORD;
        dmem_addr    = '0;
        dmem_wdata   = '0;
        port_req_ack = '0;
        port_resp    = '0;
        port_rdata   = '0;
    endtask

    task automatic req(input logic [31:0] a, input type_scr1_mem_cmd_e c);
        dmem_req  = 1'b1;
        dmem_cmd  = c;
        dmem_addr = a;
    endtask

    task automatic presp(input int p, input logic [1:0] r, input logic [31:0] d);
        port_resp[p]  = r;
        port_rdata[p] = d;
    endtask

    task automatic expect_resp(input logic [1:0] r, input logic [31:0] d);
        exp_q.push_back('{resp: r, rdata: d});
    endtask

    initial begin
        rst_n = 1'b0;
        idle();

        // Reset: outputs quiet even with a live request and acking targets
        repeat (2) begin
            cyc(); idle(); rst_n = 1'b0;
            req(32'h0001_0000, SCR1_MEM_CMD_RD); port_req_ack = '1;
            #3;
            chk("rst_port_req", 32'(port_req), 32'h0);
            chk("rst_ack", 32'(dmem_req_ack), 32'h0);
            chk("rst_resp", 32'(dmem_resp), 32'(SCR1_MEM_RESP_NOTRDY));
        end
        cyc(); idle(); rst_n = 1'b1;
        #3;
        chk("post_rst_resp", 32'(dmem_resp), 32'(SCR1_MEM_RESP_NOTRDY));

        // Back-to-back reads to port1, responses one cycle after each accept
        cyc(); idle(); req(32'h0001_0000, SCR1_MEM_CMD_RD); port_req_ack[1] = 1'b1;
        #3;
        chk("t1_port_req", 32'(port_req), 32'h2);
        chk("t1_ack_a", 32'(dmem_req_ack), 32'h1);
        chk("t1_addr1", port_addr[1], 32'h0001_0000);
        chk("t1_width0_err", 32'(port_width[0]), 32'(SCR1_MEM_WIDTH_ERROR));
        chk("t1_addr2_zero", port_addr[2], 32'h0);
        cyc(); idle(); req(32'h0001_0004, SCR1_MEM_CMD_RD); port_req_ack[1] = 1'b1;
        presp(1, SCR1_MEM_RESP_RDY_OK, 32'h1111_0000);
        expect_resp(SCR1_MEM_RESP_RDY_OK, 32'h1111_0000);
        #3;
        chk("t1_ack_b", 32'(dmem_req_ack), 32'h1);
        chk("t1_addr1_b", port_addr[1], 32'h0001_0004);
        cyc(); idle(); presp(1, SCR1_MEM_RESP_RDY_OK, 32'h2222_0004);
        expect_resp(SCR1_MEM_RESP_RDY_OK, 32'h2222_0004);
        #3;
        chk("t1_port_req_idle", 32'(port_req), 32'h0);
        cyc(); idle();
        #3;
        chk("t1_resp_empty", 32'(dmem_resp), 32'(SCR1_MEM_RESP_NOTRDY));

        // Port switch blocked until port1 responds; accepted in the pop cycle
        cyc(); idle(); req(32'h0001_0008, SCR1_MEM_CMD_RD); port_req_ack[1] = 1'b1;
        #3;
        chk("t2_ack_p1", 32'(dmem_req_ack), 32'h1);
        repeat (2) begin
            cyc(); idle(); req(32'h0002_0000, SCR1_MEM_CMD_RD); port_req_ack[2] = 1'b1;
            #3;
            chk("t2_ack_blocked", 32'(dmem_req_ack), 32'h0);
            chk("t2_req_blocked", 32'(port_req), 32'h0);
        end
        cyc(); idle(); req(32'h0002_0000, SCR1_MEM_CMD_RD); port_req_ack[2] = 1'b1;
        presp(1, SCR1_MEM_RESP_RDY_OK, 32'h3333_0008);
        expect_resp(SCR1_MEM_RESP_RDY_OK, 32'h3333_0008);
        #3;
        chk("t2_ack_switch", 32'(dmem_req_ack), 32'h1);
        chk("t2_req_switch", 32'(port_req), 32'h4);
        cyc(); idle(); presp(2, SCR1_MEM_RESP_RDY_OK, 32'h4444_0000);
        expect_resp(SCR1_MEM_RESP_RDY_OK, 32'h4444_0000);
        #3;

        // Unmapped address: immediate ack, RDY_ER with zero data next cycle
        cyc(); idle(); req(32'hF000_0000, SCR1_MEM_CMD_RD);
        expect_resp(SCR1_MEM_RESP_RDY_ER, 32'h0);
        #3;
        chk("t3_ack", 32'(dmem_req_ack), 32'h1);
        chk("t3_no_port_req", 32'(port_req), 32'h0);
        chk("t3_resp_c0", 32'(dmem_resp), 32'(SCR1_MEM_RESP_NOTRDY));
        cyc(); idle(); port_rdata[0] = 32'hBEEF_BEEF;
        #3;
        chk("t3_resp_c1", 32'(dmem_resp), 32'(SCR1_MEM_RESP_RDY_ER));
        chk("t3_rdata_c1", dmem_rdata, 32'h0);

        // Tracker full while port holds NOTRDY
        cyc(); idle(); req(32'h0001_0000, SCR1_MEM_CMD_RD); port_req_ack[1] = 1'b1;
        #3;
        chk("t4_ack_a", 32'(dmem_req_ack), 32'h1);
        cyc(); idle(); req(32'h0001_0004, SCR1_MEM_CMD_RD); port_req_ack[1] = 1'b1;
        #3;
        chk("t4_ack_b", 32'(dmem_req_ack), 32'h1);
        repeat (2) begin
            cyc(); idle(); req(32'h0001_0008, SCR1_MEM_CMD_RD); port_req_ack[1] = 1'b1;
            #3;
            chk("t4_ack_full", 32'(dmem_req_ack), 32'h0);
            chk("t4_req_full", 32'(port_req), 32'h0);
        end
        cyc(); idle(); req(32'h0001_0008, SCR1_MEM_CMD_RD); port_req_ack[1] = 1'b1;
        presp(1, SCR1_MEM_RESP_RDY_OK, 32'h5555_0000);
        expect_resp(SCR1_MEM_RESP_RDY_OK, 32'h5555_0000);
        #3;
        chk("t4_ack_pop", 32'(dmem_req_ack), 32'h1);
        cyc(); idle(); presp(1, SCR1_MEM_RESP_RDY_OK, 32'h6666_0004);
        expect_resp(SCR1_MEM_RESP_RDY_OK, 32'h6666_0004);
        cyc(); idle(); presp(1, SCR1_MEM_RESP_RDY_OK, 32'h7777_0008);
        expect_resp(SCR1_MEM_RESP_RDY_OK, 32'h7777_0008);
        cyc(); idle();
        #3;
        chk("t4_resp_empty", 32'(dmem_resp), 32'(SCR1_MEM_RESP_NOTRDY));

        // Target error on the first of two reads does not flush the second
        cyc(); idle(); req(32'h0001_0010, SCR1_MEM_CMD_RD); port_req_ack[1] = 1'b1;
        #3;
        chk("t5_ack_a", 32'(dmem_req_ack), 32'h1);
        cyc(); idle(); req(32'h0001_0014, SCR1_MEM_CMD_RD); port_req_ack[1] = 1'b1;
        #3;
        chk("t5_ack_b", 32'(dmem_req_ack), 32'h1);
        cyc(); idle(); presp(1, SCR1_MEM_RESP_RDY_ER, 32'hDEAD_0010);
        expect_resp(SCR1_MEM_RESP_RDY_ER, 32'hDEAD_0010);
        cyc(); idle(); presp(1, SCR1_MEM_RESP_RDY_OK, 32'h8888_0014);
        expect_resp(SCR1_MEM_RESP_RDY_OK, 32'h8888_0014);
        cyc(); idle(); req(32'h0002_0000, SCR1_MEM_CMD_RD); port_req_ack[2] = 1'b1;
        #3;
        chk("t5_empty_resp", 32'(dmem_resp), 32'(SCR1_MEM_RESP_NOTRDY));
        chk("t5_ack_p2", 32'(dmem_req_ack), 32'h1);
        chk("t5_req_p2", 32'(port_req), 32'h4);
        cyc(); idle(); presp(2, SCR1_MEM_RESP_RDY_OK, 32'h9999_0000);
        expect_resp(SCR1_MEM_RESP_RDY_OK, 32'h9999_0000);

        // Reset with two entries in flight; late responses ignored afterwards
        cyc(); idle(); req(32'h0001_0000, SCR1_MEM_CMD_RD); port_req_ack[1] = 1'b1;
        #3;
        chk("t6_ack_a", 32'(dmem_req_ack), 32'h1);
        cyc(); idle(); req(32'h0001_0004, SCR1_MEM_CMD_RD); port_req_ack[1] = 1'b1;
        #3;
        chk("t6_ack_b", 32'(dmem_req_ack), 32'h1);
        cyc(); idle(); rst_n = 1'b0;
        req(32'h0001_0008, SCR1_MEM_CMD_RD); port_req_ack[1] = 1'b1;
        presp(1, SCR1_MEM_RESP_RDY_OK, 32'hBAD0_0000);
        #3;
        chk("t6_rst_ack", 32'(dmem_req_ack), 32'h0);
        chk("t6_rst_port_req", 32'(port_req), 32'h0);
        chk("t6_rst_resp", 32'(dmem_resp), 32'(SCR1_MEM_RESP_NOTRDY));
        cyc(); idle(); rst_n = 1'b1;
        presp(1, SCR1_MEM_RESP_RDY_OK, 32'hBAD0_0004);
        #3;
        chk("t6_late_resp", 32'(dmem_resp), 32'(SCR1_MEM_RESP_NOTRDY));
        chk("t6_late_rdata", dmem_rdata, 32'h0);
        cyc(); idle(); req(32'h0003_0000, SCR1_MEM_CMD_WR);
        dmem_wdata = 32'h1234_5678; port_req_ack[3] = 1'b1;
        #3;
        chk("t6_ack_new", 32'(dmem_req_ack), 32'h1);
        chk("t6_req_new", 32'(port_req), 32'h8);
        chk("t6_cmd", 32'(port_cmd), 32'h8);
        chk("t6_wdata3", port_wdata[3], 32'h1234_5678);
        chk("t6_wdata0_zero", port_wdata[0], 32'h0);
        chk("t6_width3", 32'(port_width[3]), 32'(SCR1_MEM_WIDTH_WORD));
        cyc(); idle(); presp(3, SCR1_MEM_RESP_RDY_OK, 32'hCCCC_0000);
        expect_resp(SCR1_MEM_RESP_RDY_OK, 32'hCCCC_0000);
        cyc(); idle();
        #3;
        chk("t6_resp_empty", 32'(dmem_resp), 32'(SCR1_MEM_RESP_NOTRDY));

        cyc(); idle();
        #3;
        chk("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
